// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared widths and the shadow pipeline slot type for the ID bypass tracker
package segre_pkg;

  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } dep_slot_t;

  localparam dep_slot_t DEP_SLOT_BUBBLE = '{valid: 1'b0, rd: '0, we: 1'b0, is_load: 1'b0};

  // A slot can only be a forwarding source if it is live and writes the RF.
  function automatic logic slot_writes(input dep_slot_t slot);
    return slot.valid & slot.we;
  endfunction

endpackage

// File: rtl/dep_tracker_cmp.sv
// rtl/dep_tracker_cmp.sv - compares one shadow slot's rd against both ID source registers
module dep_tracker_cmp
  import segre_pkg::*;
(
  input  dep_slot_t             slot_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic                  use_a_i,
  input  logic                  use_b_i,
  output logic [1:0]            dep_o
);

  logic hit_a;
  logic hit_b;

  // x0 is hardwired to zero, so a match on it never forms a dependency.
  always_comb begin
    hit_a    = use_a_i && (rs1_addr_i != '0) && (slot_i.rd == rs1_addr_i);
    hit_b    = use_b_i && (rs2_addr_i != '0) && (slot_i.rd == rs2_addr_i);
    dep_o[1] = slot_writes(slot_i) & hit_a;
    dep_o[0] = slot_writes(slot_i) & hit_b;
  end

endmodule

// File: rtl/dep_tracker_id.sv
// rtl/dep_tracker_id.sv - EX/MEM/WB destination shadow pipeline, bypass dependency and load-use stall generation (optional DEP_TRACKER_PERF_EN stall counter)
module dep_tracker_id
  import segre_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_id_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id_i,
  input  logic                  rd_src_a_id_i,
  input  logic                  rd_src_b_id_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_id_i,
  input  logic                  rf_we_id_i,
  input  logic                  is_load_id_i,
  input  logic                  pipe_en_i,
  input  logic                  flush_i,
  output logic                  valid_ex_o,
  output logic                  valid_mem_o,
  output logic                  valid_wb_o,
  output logic                  data_produced_ex_o,
  output logic                  data_produced_mem_o,
  output logic                  data_produced_wb_o,
  output logic                  depEX_src_a_o,
  output logic                  depEX_src_b_o,
  output logic                  depMEM_src_a_o,
  output logic                  depMEM_src_b_o,
  output logic                  depWB_src_a_o,
  output logic                  depWB_src_b_o,
  output logic                  stall_id_o
`ifdef DEP_TRACKER_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  dep_slot_t ex_q;
  dep_slot_t mem_q;
  dep_slot_t wb_q;
  dep_slot_t id_entry;
  logic      use_a;
  logic      use_b;
  logic      issue;
  logic [1:0] dep_ex;
  logic [1:0] dep_mem;
  logic [1:0] dep_wb;

  // Pack the ID instruction as a slot and qualify its source reads with valid_id_i.
  always_comb begin
    id_entry.valid   = 1'b1;
    id_entry.rd      = rd_addr_id_i;
    id_entry.we      = rf_we_id_i;
    id_entry.is_load = is_load_id_i;
    use_a            = valid_id_i & rd_src_a_id_i;
    use_b            = valid_id_i & rd_src_b_id_i;
  end

  dep_tracker_cmp u_cmp_ex (
    .slot_i     (ex_q),
    .rs1_addr_i (rs1_addr_id_i),
    .rs2_addr_i (rs2_addr_id_i),
    .use_a_i    (use_a),
    .use_b_i    (use_b),
    .dep_o      (dep_ex)
  );

  dep_tracker_cmp u_cmp_mem (
    .slot_i     (mem_q),
    .rs1_addr_i (rs1_addr_id_i),
    .rs2_addr_i (rs2_addr_id_i),
    .use_a_i    (use_a),
    .use_b_i    (use_b),
    .dep_o      (dep_mem)
  );

  dep_tracker_cmp u_cmp_wb (
    .slot_i     (wb_q),
    .rs1_addr_i (rs1_addr_id_i),
    .rs2_addr_i (rs2_addr_id_i),
    .use_a_i    (use_a),
    .use_b_i    (use_b),
    .dep_o      (dep_wb)
  );

  // A load in EX has no data until MEM, so a consumer of it must wait one bubble.
  always_comb begin
    stall_id_o = ex_q.valid & ex_q.is_load & (dep_ex[1] | dep_ex[0]);
    issue      = valid_id_i & ~stall_id_o & ~flush_i;
  end

  // Shadow pipeline advance: shift on pipe_en_i, insert a bubble when ID does not issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= DEP_SLOT_BUBBLE;
      mem_q <= DEP_SLOT_BUBBLE;
      wb_q  <= DEP_SLOT_BUBBLE;
    end else if (pipe_en_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= issue ? id_entry : DEP_SLOT_BUBBLE;
    end
  end

  // Per-stage status toward the ID bypass controller.
  always_comb begin
    valid_ex_o          = ex_q.valid;
    valid_mem_o         = mem_q.valid;
    valid_wb_o          = wb_q.valid;
    data_produced_ex_o  = slot_writes(ex_q) & ~ex_q.is_load;
    data_produced_mem_o = slot_writes(mem_q);
    data_produced_wb_o  = slot_writes(wb_q);
    depEX_src_a_o       = dep_ex[1];
    depEX_src_b_o       = dep_ex[0];
    depMEM_src_a_o      = dep_mem[1];
    depMEM_src_b_o      = dep_mem[0];
    depWB_src_a_o       = dep_wb[1];
    depWB_src_b_o       = dep_wb[0];
  end

`ifdef DEP_TRACKER_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count cycles lost to load-use stalls, saturating rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_id_o && pipe_en_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dep_tracker_id.sv
// tb/tb_dep_tracker_id.sv - self-checking bench for dep_tracker_id against an in-flight instruction model
module tb_dep_tracker_id;
  import segre_pkg::*;

  logic clk = 1'b0;
  logic rst, vid, ua, ub, we, ld, pen, fl;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic valid_ex, valid_mem, valid_wb, dp_ex, dp_mem, dp_wb;
  logic dex_a, dex_b, dmem_a, dmem_b, dwb_a, dwb_b, stall;
`ifdef DEP_TRACKER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dep_tracker_id dut (
    .clk_i(clk), .rst_i(rst), .valid_id_i(vid),
    .rs1_addr_id_i(rs1), .rs2_addr_id_i(rs2),
    .rd_src_a_id_i(ua), .rd_src_b_id_i(ub),
    .rd_addr_id_i(rd), .rf_we_id_i(we), .is_load_id_i(ld),
    .pipe_en_i(pen), .flush_i(fl),
    .valid_ex_o(valid_ex), .valid_mem_o(valid_mem), .valid_wb_o(valid_wb),
    .data_produced_ex_o(dp_ex), .data_produced_mem_o(dp_mem), .data_produced_wb_o(dp_wb),
    .depEX_src_a_o(dex_a), .depEX_src_b_o(dex_b),
    .depMEM_src_a_o(dmem_a), .depMEM_src_b_o(dmem_b),
    .depWB_src_a_o(dwb_a), .depWB_src_b_o(dwb_b),
    .stall_id_o(stall)
`ifdef DEP_TRACKER_PERF_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  // {valid ex,mem,wb, produced ex,mem,wb, depEX a,b, depMEM a,b, depWB a,b, stall}
  logic [12:0] obs;
  assign obs = {valid_ex, valid_mem, valid_wb, dp_ex, dp_mem, dp_wb,
                dex_a, dex_b, dmem_a, dmem_b, dwb_a, dwb_b, stall};

  // Model: the instructions currently in flight, index 0 = youngest (EX).
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } instr_t;
  instr_t m[3];
  logic [31:0] mcnt;

  function automatic bit reads(int s, int src, bit use_it);
    return use_it && vid && src != 0 && m[s].v && m[s].we && m[s].rd == src;
  endfunction

  function automatic logic [12:0] expect_vec();
    logic [12:0] e;
    bit st;
    st = m[0].v && m[0].ld && (reads(0, int'(rs1), ua) || reads(0, int'(rs2), ub));
    e = {m[0].v, m[1].v, m[2].v,
         m[0].v && m[0].we && !m[0].ld, m[1].v && m[1].we, m[2].v && m[2].we,
         reads(0, int'(rs1), ua), reads(0, int'(rs2), ub),
         reads(1, int'(rs1), ua), reads(1, int'(rs2), ub),
         reads(2, int'(rs1), ua), reads(2, int'(rs2), ub), st};
    return e;
  endfunction

  task automatic set_id(bit v, int a1, int a2, bit sa, bit sb, int d, bit w, bit l);
    vid = v; rs1 = a1[REG_ADDR_W-1:0]; rs2 = a2[REG_ADDR_W-1:0];
    ua = sa; ub = sb; rd = d[REG_ADDR_W-1:0]; we = w; ld = l;
    #1;
  endtask

  task automatic tick();
    logic [12:0] e;
    bit st;
    e  = expect_vec();
    st = e[0];
    @(posedge clk);
    if (rst) begin
      for (int s = 0; s < 3; s++) m[s] = '{0, 0, 0, 0};
      mcnt = 0;
    end else if (pen) begin
      if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
      m[2] = m[1];
      m[1] = m[0];
      m[0] = '{vid && !st && !fl, int'(rd), we, ld};
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; pen = 1; fl = 0;
    for (int i = 0; i < 2; i++) begin
      set_id(1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom),
             1'($urandom), $urandom_range(0, 31), 1'($urandom), 1'($urandom));
      pen = 1'($urandom); fl = 1'($urandom);
      tick();
      checks++;
      if (obs !== 13'd0) begin
        errors++; $display("FAIL reset_cycle%0d got=%b want=%b", i, obs, 13'd0);
      end
    end
    rst = 0; pen = 0; fl = 0;
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    set_id(1, 3, 3, 1, 1, 4, 1, 0);
    checks++;
    if (obs !== 13'd0) begin
      errors++; $display("FAIL reset_hold_after_release got=%b want=%b", obs, 13'd0);
    end
  endtask

  task automatic test_alu_back_to_back();
    pen = 1; fl = 0;
    set_id(1, 1, 2, 1, 1, 5, 1, 0);
    tick();
    set_id(1, 5, 5, 1, 1, 6, 1, 0);
    checks++;
    if ({dex_a, dex_b, dp_ex, stall} !== 4'b1110) begin
      errors++; $display("FAIL alu_b2b {depa,depb,prod,stall} got=%b want=1110", {dex_a, dex_b, dp_ex, stall});
    end
    tick();
  endtask

  task automatic test_load_use();
    pen = 1; fl = 0;
    set_id(1, 1, 0, 1, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 0, 1, 1, 8, 1, 0);
    checks++;
    if ({stall, dex_a, dex_b, dp_ex} !== 4'b1100) begin
      errors++; $display("FAIL load_use_stall {stall,depa,depb,prod} got=%b want=1100", {stall, dex_a, dex_b, dp_ex});
    end
    tick();
    checks++;
    if ({stall, valid_ex, dmem_a, dp_mem} !== 4'b0011) begin
      errors++; $display("FAIL load_use_bubble {stall,vex,depmem_a,prodmem} got=%b want=0011", {stall, valid_ex, dmem_a, dp_mem});
    end
    tick();
    checks++;
    if ({valid_ex, valid_mem, dwb_a} !== 3'b101) begin
      errors++; $display("FAIL load_use_issue {vex,vmem,depwb_a} got=%b want=101", {valid_ex, valid_mem, dwb_a});
    end
  endtask

  task automatic test_x0_and_unused();
    pen = 1; fl = 0;
    set_id(1, 1, 2, 0, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 0, 1, 1, 10, 1, 0);
    checks++;
    if ({dex_a, dex_b, valid_ex} !== 3'b001) begin
      errors++; $display("FAIL x0_no_dep {depa,depb,vex} got=%b want=001", {dex_a, dex_b, valid_ex});
    end
    set_id(1, 1, 2, 0, 0, 9, 1, 0);
    tick();
    set_id(1, 9, 9, 1, 0, 13, 1, 0);
    checks++;
    if ({dex_a, dex_b} !== 2'b10) begin
      errors++; $display("FAIL unused_src_b {depa,depb} got=%b want=10", {dex_a, dex_b});
    end
    set_id(1, 13, 13, 1, 1, 13, 1, 0);
    checks++;
    if ({dex_a, dex_b} !== 2'b00) begin
      errors++; $display("FAIL self_dep {depa,depb} got=%b want=00", {dex_a, dex_b});
    end
    tick();
  endtask

  task automatic test_hold_and_flush();
    pen = 1; fl = 0;
    set_id(1, 0, 0, 0, 0, 3, 1, 0);  tick();
    set_id(1, 0, 0, 0, 0, 4, 1, 0);  tick();
    set_id(1, 0, 0, 0, 0, 11, 1, 0); tick();
    pen = 0; fl = 1;
    set_id(1, 3, 11, 1, 1, 12, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 13'b111_111_01_00_10_0) begin
        errors++; $display("FAIL hold_cycle%0d got=%b want=%b", i, obs, 13'b111_111_01_00_10_0);
      end
    end
    pen = 1; fl = 1;
    tick();
    fl = 0;
    set_id(1, 11, 4, 1, 1, 14, 1, 0);
    checks++;
    if (obs !== 13'b011_011_00_10_01_0) begin
      errors++; $display("FAIL flush_shift got=%b want=%b", obs, 13'b011_011_00_10_01_0);
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      pen = ($urandom_range(0, 99) < 75);
      fl  = ($urandom_range(0, 99) < 15);
      set_id(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      e = expect_vec();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL random_cycle%0d got=%b want=%b", i, obs, e);
      end
`ifdef DEP_TRACKER_PERF_EN
      checks++;
      if (stall_cnt !== mcnt) begin
        errors++; $display("FAIL random_cnt%0d got=%0d want=%0d", i, stall_cnt, mcnt);
      end
`endif
      tick();
    end
    rst = 0; pen = 1; fl = 0;
  endtask

`ifdef DEP_TRACKER_PERF_EN
  task automatic load_use_pair();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); tick();
    set_id(1, 7, 0, 1, 0, 8, 1, 0); tick();
    tick();
  endtask

  task automatic test_perf();
    rst = 1; pen = 1; fl = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) load_use_pair();
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++; $display("FAIL perf_count got=%0d want=4", stall_cnt);
    end
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    mcnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) load_use_pair();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL perf_saturate got=%h want=ffffffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    for (int s = 0; s < 3; s++) m[s] = '{0, 0, 0, 0};
    mcnt = 0;
    rst = 1; pen = 0; fl = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_x0_and_unused();
    test_hold_and_flush();
    test_random();
`ifdef DEP_TRACKER_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
